// File: rtl/i2c_pkg.sv
// Shared definitions for the sensor poller: FSM states, I2C master command-bit
// layout and the sensor register map.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_CMD,
    ST_WR_DATA,
    ST_RD_CMD,
    ST_RD_DATA,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam int unsigned CMD_START          = 0;
  localparam int unsigned CMD_READ           = 1;
  localparam int unsigned CMD_WRITE          = 2;
  localparam int unsigned CMD_WRITE_MULTIPLE = 3;
  localparam int unsigned CMD_STOP           = 4;
  localparam int unsigned CMD_W              = 5;

  typedef logic [CMD_W-1:0] cmd_bits_t;

  localparam logic [6:0] SENSOR_DEV_ADDR = 7'h29;
  localparam logic [7:0] SENSOR_REG_ADDR = 8'h14;

  function automatic cmd_bits_t cmd_bits(input logic start, input logic read,
                                         input logic write, input logic stop);
    cmd_bits_t b;
    b             = '0;
    b[CMD_START]  = start;
    b[CMD_READ]   = read;
    b[CMD_WRITE]  = write;
    b[CMD_STOP]   = stop;
    return b;
  endfunction

  // Low n bytes set; n >= 4 selects the full word.
  function automatic logic [31:0] byte_mask(input int unsigned n);
    if (n >= 4) return '1;
    return (32'd1 << (n * 8)) - 32'd1;
  endfunction

endpackage

// File: rtl/i2c_sensor_poller_if.sv
// Command/data stream bundle between the sensor poller and the shared I2C master.
interface i2c_sensor_poller_if;
  logic [6:0] cmd_address;
  logic       cmd_start;
  logic       cmd_read;
  logic       cmd_write;
  logic       cmd_write_multiple;
  logic       cmd_stop;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic       data_in_ready;
  logic       data_in_last;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready;
  logic       data_out_last;
  logic       missed_ack;

  modport master (
    output cmd_address, cmd_start, cmd_read, cmd_write, cmd_write_multiple,
           cmd_stop, cmd_valid, data_in, data_in_valid, data_in_last,
           data_out_ready,
    input  cmd_ready, data_in_ready, data_out, data_out_valid, data_out_last,
           missed_ack
  );

  modport slave (
    input  cmd_address, cmd_start, cmd_read, cmd_write, cmd_write_multiple,
           cmd_stop, cmd_valid, data_in, data_in_valid, data_in_last,
           data_out_ready,
    output cmd_ready, data_in_ready, data_out, data_out_valid, data_out_last,
           missed_ack
  );
endinterface

// File: rtl/i2c_poll_timer.sv
// Clearable cycle counter with a terminal-count pulse on its LIMIT-th enabled cycle.
module i2c_poll_timer #(
    parameter int unsigned LIMIT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tc
);
    logic [31:0] count;

    assign tc = enable && (count == 32'(LIMIT - 1));

    always_ff @(posedge clk) begin
        if (reset || clear || tc) count <= '0;
        else if (enable)          count <= count + 32'd1;
    end
endmodule

// File: rtl/i2c_sensor_poller.sv
// Reads NUM_BYTES consecutive sensor registers through the I2C master on trigger
// or auto-poll, and presents them big-endian in result.
module i2c_sensor_poller
    import i2c_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR       = SENSOR_DEV_ADDR,
    parameter logic [7:0]  REG_ADDR       = SENSOR_REG_ADDR,
    parameter int unsigned NUM_BYTES      = 2,
    parameter int unsigned POLL_CYCLES    = 2500000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  trigger,
    input  logic                  auto_poll,
    i2c_sensor_poller_if.master   bus,
    output logic                  busy,
    output logic [31:0]           result,
    output logic                  result_valid,
    output logic                  error
);
    localparam logic [1:0]  LAST_K      = 2'(NUM_BYTES - 1);
    localparam logic [31:0] RESULT_MASK = byte_mask(NUM_BYTES);

    state_t      state;
    logic [1:0]  k;
    logic [23:0] shadow;
    cmd_bits_t   cmd;
    logic [31:0] rd_word;
    logic        idle, launch, poll_tc, wd_tc, abort;
    logic        unused_last;

    assign idle        = (state == ST_IDLE);
    assign launch      = idle && (trigger || poll_tc);
    assign rd_word     = {shadow, bus.data_out};
    assign unused_last = bus.data_out_last;
    // DONE/ERR always return to IDLE, so only the bus-facing states can abort.
    assign abort = (state inside {ST_WR_CMD, ST_WR_DATA, ST_RD_CMD, ST_RD_DATA})
                   && (bus.missed_ack || wd_tc);

    assign bus.cmd_start          = cmd[CMD_START];
    assign bus.cmd_read           = cmd[CMD_READ];
    assign bus.cmd_write          = cmd[CMD_WRITE];
    assign bus.cmd_write_multiple = cmd[CMD_WRITE_MULTIPLE];
    assign bus.cmd_stop           = cmd[CMD_STOP];

    i2c_poll_timer #(.LIMIT(POLL_CYCLES)) u_poll (
        .clk(clk), .reset(reset), .enable(auto_poll && idle), .clear(launch), .tc(poll_tc)
    );

    i2c_poll_timer #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
        .clk(clk), .reset(reset), .enable(!idle), .clear(idle), .tc(wd_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= ST_IDLE;
            k                  <= '0;
            shadow             <= '0;
            cmd                <= '0;
            bus.cmd_address    <= '0;
            bus.cmd_valid      <= 1'b0;
            bus.data_in        <= '0;
            bus.data_in_valid  <= 1'b0;
            bus.data_in_last   <= 1'b0;
            bus.data_out_ready <= 1'b0;
            busy               <= 1'b0;
            result             <= '0;
            result_valid       <= 1'b0;
            error              <= 1'b0;
        end else if (abort) begin
            state              <= ST_ERR;
            bus.cmd_valid      <= 1'b0;
            bus.data_in_valid  <= 1'b0;
            bus.data_in_last   <= 1'b0;
            bus.data_out_ready <= 1'b0;
            shadow             <= '0;
            error              <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: if (launch) begin
                    state           <= ST_WR_CMD;
                    busy            <= 1'b1;
                    bus.cmd_address <= DEV_ADDR;
                    cmd             <= cmd_bits(1'b1, 1'b0, 1'b1, 1'b0);
                    bus.cmd_valid   <= 1'b1;
                end
                ST_WR_CMD: if (bus.cmd_ready) begin
                    state             <= ST_WR_DATA;
                    bus.cmd_valid     <= 1'b0;
                    bus.data_in       <= REG_ADDR;
                    bus.data_in_valid <= 1'b1;
                    bus.data_in_last  <= 1'b1;
                end
                ST_WR_DATA: if (bus.data_in_ready) begin
                    state             <= ST_RD_CMD;
                    bus.data_in_valid <= 1'b0;
                    bus.data_in_last  <= 1'b0;
                    k                 <= '0;
                    cmd               <= cmd_bits(1'b1, 1'b1, 1'b0, LAST_K == 2'd0);
                    bus.cmd_valid     <= 1'b1;
                end
                ST_RD_CMD: if (bus.cmd_ready) begin
                    state              <= ST_RD_DATA;
                    bus.cmd_valid      <= 1'b0;
                    bus.data_out_ready <= 1'b1;
                end
                ST_RD_DATA: if (bus.data_out_valid) begin
                    bus.data_out_ready <= 1'b0;
                    if (k == LAST_K) begin
                        state        <= ST_DONE;
                        result       <= rd_word & RESULT_MASK;
                        result_valid <= 1'b1;
                        shadow       <= '0;
                    end else begin
                        state         <= ST_RD_CMD;
                        shadow        <= rd_word[23:0];
                        k             <= k + 2'd1;
                        cmd           <= cmd_bits(1'b0, 1'b1, 1'b0, (k + 2'd1) == LAST_K);
                        bus.cmd_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state        <= ST_IDLE;
                    result_valid <= 1'b0;
                    busy         <= 1'b0;
                end
                ST_ERR: begin
                    state <= ST_IDLE;
                    error <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_sensor_poller.sv
// Directed bench for i2c_sensor_poller: the bench plays the I2C master and checks
// command order, handshake stability, NACK/timeout recovery, reset and auto-poll.
module tb_i2c_sensor_poller;
    logic        clk = 1'b0;
    logic        reset, trigger, auto_poll;
    logic        busy, result_valid, error;
    logic [31:0] result;
    logic        rsp_en;

    i2c_sensor_poller_if bus ();

    i2c_sensor_poller #(
        .DEV_ADDR(7'h29), .REG_ADDR(8'h14), .NUM_BYTES(2),
        .POLL_CYCLES(100), .TIMEOUT_CYCLES(50)
    ) dut (
        .clk(clk), .reset(reset), .trigger(trigger), .auto_poll(auto_poll),
        .bus(bus), .busy(busy), .result(result),
        .result_valid(result_valid), .error(error)
    );

    always #5 clk = ~clk;

    // {start, read, write, stop, address}
    localparam logic [10:0] EXP_WR  = {4'b1010, 7'h29};
    localparam logic [10:0] EXP_RD0 = {4'b1100, 7'h29};
    localparam logic [10:0] EXP_RD1 = {4'b0101, 7'h29};

    logic [10:0] cmd_q[$];
    logic [8:0]  din_q[$];
    int          launch_q[$];
    int          cyc = 0, rv_cnt = 0, err_cnt = 0, cv_cnt = 0, rsp_idx = 0;
    logic        prev_busy = 1'b0, wm_seen = 1'b0;
    int          n_checks = 0, n_errors = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset) begin
            if (bus.cmd_valid && bus.cmd_ready)
                cmd_q.push_back({bus.cmd_start, bus.cmd_read, bus.cmd_write,
                                 bus.cmd_stop, bus.cmd_address});
            if (bus.data_in_valid && bus.data_in_ready)
                din_q.push_back({bus.data_in_last, bus.data_in});
            if (bus.data_out_valid && bus.data_out_ready) rsp_idx <= rsp_idx + 1;
            if (bus.cmd_valid) cv_cnt <= cv_cnt + 1;
            if (bus.cmd_write_multiple) wm_seen <= 1'b1;
            if (result_valid) rv_cnt <= rv_cnt + 1;
            if (error) err_cnt <= err_cnt + 1;
            if (busy && !prev_busy) launch_q.push_back(cyc);
        end
        prev_busy <= busy;
    end

    // Read-data responder: answers one cycle after data_out_ready rises.
    always @(negedge clk) begin
        bus.data_out_valid = rsp_en && bus.data_out_ready;
        bus.data_out       = rsp_idx[0] ? 8'hCD : 8'hAB;
        bus.data_out_last  = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic pulse_trigger();
        @(negedge clk) trigger = 1'b1;
        @(negedge clk) trigger = 1'b0;
    endtask

    task automatic wait_result(input string tag);
        logic got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (result_valid) begin got = 1'b1; break; end
            @(negedge clk);
        end
        chk(tag, {31'd0, got}, 32'd1);
    endtask

    int cb, db, rvb, eb, cvb, lb, nwr, bcount, errat;
    logic got;

    initial begin
        reset = 1'b1; trigger = 1'b0; auto_poll = 1'b0; rsp_en = 1'b1;
        bus.cmd_ready = 1'b1; bus.data_in_ready = 1'b1; bus.missed_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_flags", {22'd0, busy, result_valid, error, bus.cmd_valid,
                            bus.data_in_valid, bus.data_out_ready, bus.cmd_start,
                            bus.cmd_read, bus.cmd_write, bus.cmd_stop}, 32'd0);
        chk("reset_result", result, 32'd0);
        reset = 1'b0;

        // Basic read of 0xAB, 0xCD with an always-ready master
        cb = cmd_q.size(); db = din_q.size(); rvb = rv_cnt; eb = err_cnt;
        pulse_trigger();
        chk("launch_latency", {30'd0, bus.cmd_valid, busy}, 32'd3);
        wait_result("basic_done");
        chk("basic_result", result, 32'h0000ABCD);
        @(negedge clk);
        chk("basic_rv_pulse", {30'd0, result_valid, busy}, 32'd0);
        chk("basic_cmd_count", cmd_q.size() - cb, 32'd3);
        chk("basic_cmd0", {21'd0, cmd_q[cb]},     {21'd0, EXP_WR});
        chk("basic_cmd1", {21'd0, cmd_q[cb + 1]}, {21'd0, EXP_RD0});
        chk("basic_cmd2", {21'd0, cmd_q[cb + 2]}, {21'd0, EXP_RD1});
        chk("basic_din_count", din_q.size() - db, 32'd1);
        chk("basic_din0", {23'd0, din_q[db]}, {23'd0, 9'h114});
        chk("basic_rv_count", rv_cnt - rvb, 32'd1);
        chk("basic_no_error", err_cnt - eb, 32'd0);

        // Command back-pressure: valid and payload held while cmd_ready is low
        cb = cmd_q.size();
        bus.cmd_ready = 1'b0;
        pulse_trigger();
        for (int i = 0; i < 5; i++) begin
            chk("stall_cmd_valid", {31'd0, bus.cmd_valid}, 32'd1);
            chk("stall_cmd_payload", {21'd0, bus.cmd_start, bus.cmd_read, bus.cmd_write,
                                      bus.cmd_stop, bus.cmd_address}, {21'd0, EXP_WR});
            @(negedge clk);
        end
        bus.cmd_ready = 1'b1;
        wait_result("stall_done");
        chk("stall_result", result, 32'h0000ABCD);
        nwr = 0;
        for (int i = cb; i < cmd_q.size(); i++) if (cmd_q[i][8]) nwr++;
        chk("stall_one_write", nwr, 32'd1);
        @(negedge clk);

        // NACK while the register pointer byte is outstanding
        eb = err_cnt;
        bus.data_in_ready = 1'b0;
        pulse_trigger();
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.data_in_valid) begin got = 1'b1; break; end
            @(negedge clk);
        end
        chk("nack_reach_wr_data", {31'd0, got}, 32'd1);
        bus.missed_ack = 1'b1;
        @(negedge clk) bus.missed_ack = 1'b0;
        chk("nack_error_pulse", {30'd0, error, bus.data_in_valid}, 32'd2);
        @(negedge clk);
        chk("nack_back_idle", {30'd0, error, busy}, 32'd0);
        cvb = cv_cnt;
        bus.data_in_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("nack_no_cmd_valid", cv_cnt - cvb, 32'd0);
        chk("nack_result_kept", result, 32'h0000ABCD);
        chk("nack_err_count", err_cnt - eb, 32'd1);

        // Watchdog: read data never arrives
        rsp_en = 1'b0;
        bcount = 0; errat = 0;
        pulse_trigger();
        for (int i = 0; i < 100; i++) begin
            if (!busy) break;
            bcount++;
            if (error && errat == 0) errat = bcount;
            @(negedge clk);
        end
        chk("timeout_error_cycle", errat, 32'd51);
        chk("timeout_busy_cycles", bcount, 32'd51);
        chk("timeout_idle", {31'd0, busy}, 32'd0);
        chk("timeout_result_kept", result, 32'h0000ABCD);

        // Reset while waiting for read data, then a normal transaction
        pulse_trigger();
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.data_out_ready) begin got = 1'b1; break; end
            @(negedge clk);
        end
        chk("rst_reach_rd_data", {31'd0, got}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_flags", {22'd0, busy, result_valid, error, bus.cmd_valid,
                          bus.data_in_valid, bus.data_out_ready, bus.cmd_start,
                          bus.cmd_read, bus.cmd_write, bus.cmd_stop}, 32'd0);
        chk("rst_result", result, 32'd0);
        reset = 1'b0; rsp_en = 1'b1;
        pulse_trigger();
        wait_result("rst_recover_done");
        chk("rst_recover_result", result, 32'h0000ABCD);
        @(negedge clk);

        // Auto-poll spacing with a trigger dropped while busy
        lb = launch_q.size(); rvb = rv_cnt;
        auto_poll = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 150; i++) begin
            if (busy) begin got = 1'b1; break; end
            @(negedge clk);
        end
        chk("poll_first_launch", {31'd0, got}, 32'd1);
        trigger = 1'b1;
        @(negedge clk) trigger = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (launch_q.size() >= lb + 3) begin got = 1'b1; break; end
            @(negedge clk);
        end
        chk("poll_three_launches", {31'd0, got}, 32'd1);
        if (got) begin
            chk("poll_spacing_1", launch_q[lb + 1] - launch_q[lb], 32'd107);
            chk("poll_spacing_2", launch_q[lb + 2] - launch_q[lb + 1], 32'd107);
        end
        auto_poll = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        @(negedge clk);
        chk("poll_rv_count", rv_cnt - rvb, 32'd3);
        chk("poll_result", result, 32'h0000ABCD);
        chk("write_multiple_zero", {31'd0, wm_seen}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
